clk_div_ctrl: RTL

Programmable clock-divider controller that generates a divided clock `clkout` and a period-start strobe from the system clock, with a glitch-free, handshaked ratio change and a clean start/stop. It sits between a configuration master (which issues ratio-change requests) and the downstream logic clocked or enabled by the divided output. It supersedes the fixed divide-by-3 divider: reset ratio is 3, and other ratios are reached at runtime.

---
 rtl/clk_div_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with a handshaked, glitch-free ratio change and clean start/stop.
// Ratio changes take effect only at period boundaries, so clkout never shows a short or long pulse.
module clk_div_ctrl #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         div_req,
  input  logic [W-1:0] div_val,
  output logic         div_ack,
  output logic         div_err,
  output logic         clkout,
  output logic         tick,
  output logic         busy
);

  localparam logic [1:0]   ST_IDLE  = 2'd0;
  localparam logic [1:0]   ST_RUN   = 2'd1;
  localparam logic [1:0]   ST_DRAIN = 2'd2;
  localparam logic [W-1:0] DIV_RST  = W'(DEFAULT_DIV);
  localparam logic [W-1:0] ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] TWO_W    = W'(2);
  localparam logic [W-1:0] ZERO_W   = {W{1'b0}};

  logic [1:0]   state_r, state_s;
  logic [W-1:0] cnt_r, cnt_s;
  logic [W-1:0] n_r, n_s;
  logic [W-1:0] p_r, p_s;
  logic         pv_r, pv_s;
  logic         div_ack_r, div_ack_s;
  logic         div_err_r, div_err_s;
  logic         clkout_r, clkout_s;
  logic         tick_r, tick_s;
  logic         busy_r, busy_s;
  logic         last_s;
  logic         cap_s;

  // Length of the high phase, (n+1)>>1, computed one bit wider so n = 2^W-1 cannot overflow.
  function automatic logic [W:0] high_len(input logic [W-1:0] n);
    return ({1'b0, n} + {{W{1'b0}}, 1'b1}) >> 1'b1;
  endfunction

  assign last_s = (cnt_r == (n_r - ONE_W));
  // The ack cycle is excluded so a requester still holding div_req is not re-captured.
  assign cap_s  = div_req && !pv_r && !div_ack_r;

  // Next-state, counter and ratio-handshake logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    n_s       = n_r;
    p_s       = p_r;
    pv_s      = pv_r;
    div_ack_s = 1'b0;
    div_err_s = 1'b0;
    tick_s    = 1'b0;
    clkout_s  = 1'b0;
    busy_s    = 1'b0;

    if (cap_s && (div_val < TWO_W)) begin
      div_ack_s = 1'b1;
      div_err_s = 1'b1;
    end else if (cap_s && (state_r == ST_IDLE)) begin
      n_s       = div_val;
      div_ack_s = 1'b1;
    end else if (cap_s) begin
      p_s  = div_val;
      pv_s = 1'b1;
    end else begin
      pv_s = pv_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (pv_r) begin
          n_s       = p_r;
          pv_s      = 1'b0;
          div_ack_s = 1'b1;
        end else begin
          pv_s = pv_r;
        end
        cnt_s = ZERO_W;
        if (en) begin
          state_s = ST_RUN;
          tick_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (last_s && en) begin
          // Wrap: a ratio pending since before this edge takes effect for the new period.
          state_s = ST_RUN;
          cnt_s   = ZERO_W;
          tick_s  = 1'b1;
          if (pv_r) begin
            n_s       = p_r;
            pv_s      = 1'b0;
            div_ack_s = 1'b1;
          end else begin
            pv_s = pv_s;
          end
        end else if (last_s) begin
          state_s = ST_IDLE;
          cnt_s   = ZERO_W;
        end else begin
          cnt_s   = cnt_r + ONE_W;
          state_s = en ? ST_RUN : ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = ZERO_W;
      end
    endcase

    if (state_s != ST_IDLE) begin
      busy_s   = 1'b1;
      clkout_s = ({1'b0, cnt_s} < high_len(n_s));
    end else begin
      busy_s   = 1'b0;
      clkout_s = 1'b0;
    end
  end

  // State and registered outputs; reset drops every output and discards any pending ratio.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= ZERO_W;
      n_r       <= DIV_RST;
      p_r       <= ZERO_W;
      pv_r      <= 1'b0;
      div_ack_r <= 1'b0;
      div_err_r <= 1'b0;
      clkout_r  <= 1'b0;
      tick_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      n_r       <= n_s;
      p_r       <= p_s;
      pv_r      <= pv_s;
      div_ack_r <= div_ack_s;
      div_err_r <= div_err_s;
      clkout_r  <= clkout_s;
      tick_r    <= tick_s;
      busy_r    <= busy_s;
    end
  end

  assign div_ack = div_ack_r;
  assign div_err = div_err_r;
  assign clkout  = clkout_r;
  assign tick    = tick_r;
  assign busy    = busy_r;

endmodule
